chimp_game_ctrl: RTL and testbench

Parametrised control path for the chimp memory game, replacing the fully unrolled per-level FSM with counter-driven states.
- Tracks level, expected press, lives and best score internally.
- Drives a load handshake to the chimp datapath to place numbered tiles.
- Adds a multi-life (strike) mode and a win/game-over terminal state.
- Sits between the menu/top-level FSM and the chimp datapath/VGA drawer.

---
 rtl/chimp_pkg.sv | 17 +
 rtl/chimp_game_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_chimp_game_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/chimp_pkg.sv
// Shared definitions for the chimp memory game control path and its neighbours.
// The datapath and the top-level FSM decode oState through state_t.
package chimp_pkg;

  localparam int NUM_W_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_CHOOSE     = 3'd3,
    ST_PASS       = 3'd4,
    ST_STRIKE     = 3'd5,
    ST_GAME_OVER  = 3'd6
  } state_t;

endpackage

// File: rtl/chimp_game_ctrl.sv
// Counter-driven control FSM for the chimp memory game: level, expected press,
// lives and best score, with a load handshake toward the tile datapath.
module chimp_game_ctrl
  import chimp_pkg::*;
#(
  parameter int MAX_LEVEL   = 31,
  parameter int START_LEVEL = 4,
  parameter int LIVES       = 3,
  parameter int NUM_W       = NUM_W_DEF,
  parameter int LVL_W       = $clog2(MAX_LEVEL + 1)
) (
  input  logic             clk,
  input  logic             iResetn,
  input  logic             iKey0,
  input  logic             iEnter,
  input  logic [NUM_W-1:0] iPressNum,
  input  logic             iLoadAck,
  output logic             oLoadReq,
  output logic [LVL_W-1:0] oLoadIdx,
  output logic             oShowNums,
  output logic [LVL_W-1:0] oLevel,
  output logic [LVL_W-1:0] oExpect,
  output logic [2:0]       oLives,
  output logic [LVL_W-1:0] oScore,
  output logic             oLevelPass,
  output logic             oStrike,
  output logic             oGameOver,
  output logic             oWin,
  output logic [2:0]       oState
);

  localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);
  localparam logic [LVL_W-1:0] ZERO_L  = LVL_W'(0);
  localparam logic [LVL_W-1:0] START_L = LVL_W'(START_LEVEL);
  localparam logic [LVL_W-1:0] MAX_L   = LVL_W'(MAX_LEVEL);
  localparam logic [2:0]       LIVES_L = 3'(LIVES);

  state_t           r_state, w_state;
  logic [LVL_W-1:0] r_level, w_level;
  logic [LVL_W-1:0] r_idx, w_idx;
  logic [LVL_W-1:0] r_expect, w_expect;
  logic [LVL_W-1:0] r_score, w_score;
  logic [2:0]       r_lives, w_lives;
  logic             r_win, w_win;
  logic             r_load_req, r_show, r_pass, r_strike, r_gover, r_win_o;
  logic             w_press_hit;

  assign w_press_hit = (iPressNum == NUM_W'(r_expect));

  // Next-state and counter update; iKey0 forces the same state as reset.
  always_comb begin
    w_state  = r_state;
    w_level  = r_level;
    w_idx    = r_idx;
    w_expect = r_expect;
    w_score  = r_score;
    w_lives  = r_lives;
    w_win    = r_win;
    if (iKey0) begin
      w_state  = ST_IDLE;
      w_level  = START_L;
      w_idx    = ONE_L;
      w_expect = ONE_L;
      w_lives  = LIVES_L;
      w_score  = ZERO_L;
      w_win    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iEnter) begin
            w_state = ST_LOAD;
            w_level = START_L;
            w_lives = LIVES_L;
            w_score = ZERO_L;
            w_idx   = ONE_L;
            w_win   = 1'b0;
          end else begin
            w_state = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (iLoadAck && (r_idx < r_level)) begin
            w_idx = r_idx + ONE_L;
          end else if (iLoadAck) begin
            w_state = ST_WAIT_START;
          end else begin
            w_state = ST_LOAD;
          end
        end
        ST_WAIT_START: begin
          if (iEnter) begin
            w_state  = ST_CHOOSE;
            w_expect = ONE_L;
          end else begin
            w_state = ST_WAIT_START;
          end
        end
        ST_CHOOSE: begin
          // Any nonzero miss, including numbers above MAX_LEVEL, is a strike.
          if (iPressNum == NUM_W'(0)) begin
            w_state = ST_CHOOSE;
          end else if (w_press_hit && (r_expect < r_level)) begin
            w_expect = r_expect + ONE_L;
          end else if (w_press_hit) begin
            w_state = ST_PASS;
          end else begin
            w_state = ST_STRIKE;
          end
        end
        ST_PASS: begin
          w_score = (r_level > r_score) ? r_level : r_score;
          if (r_level == MAX_L) begin
            w_state = ST_GAME_OVER;
            w_win   = 1'b1;
          end else begin
            w_state = ST_LOAD;
            w_level = r_level + ONE_L;
            w_idx   = ONE_L;
          end
        end
        ST_STRIKE: begin
          w_lives = (r_lives != 3'd0) ? (r_lives - 3'd1) : 3'd0;
          if (r_lives <= 3'd1) begin
            w_state = ST_GAME_OVER;
            w_win   = 1'b0;
          end else begin
            w_state = ST_LOAD;
            w_idx   = ONE_L;
          end
        end
        ST_GAME_OVER: begin
          if (iEnter) begin
            w_state = ST_IDLE;
          end else begin
            w_state = ST_GAME_OVER;
          end
        end
        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and Moore outputs; outputs are decoded from the next values
  // so each one appears in the same cycle as the state it belongs to.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      r_state    <= ST_IDLE;
      r_level    <= START_L;
      r_idx      <= ONE_L;
      r_expect   <= ONE_L;
      r_score    <= ZERO_L;
      r_lives    <= LIVES_L;
      r_win      <= 1'b0;
      r_load_req <= 1'b0;
      r_show     <= 1'b0;
      r_pass     <= 1'b0;
      r_strike   <= 1'b0;
      r_gover    <= 1'b0;
      r_win_o    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_level    <= w_level;
      r_idx      <= w_idx;
      r_expect   <= w_expect;
      r_score    <= w_score;
      r_lives    <= w_lives;
      r_win      <= w_win;
      r_load_req <= (w_state == ST_LOAD);
      r_show     <= (w_state == ST_WAIT_START) ||
                    ((w_state == ST_CHOOSE) && (w_expect == ONE_L));
      r_pass     <= (w_state == ST_PASS);
      r_strike   <= (w_state == ST_STRIKE);
      r_gover    <= (w_state == ST_GAME_OVER);
      r_win_o    <= (w_state == ST_GAME_OVER) && w_win;
    end
  end

  assign oLoadReq   = r_load_req;
  assign oLoadIdx   = r_idx;
  assign oShowNums  = r_show;
  assign oLevel     = r_level;
  assign oExpect    = r_expect;
  assign oLives     = r_lives;
  assign oScore     = r_score;
  assign oLevelPass = r_pass;
  assign oStrike    = r_strike;
  assign oGameOver  = r_gover;
  assign oWin       = r_win_o;
  assign oState     = r_state;

endmodule

// File: tb/tb_chimp_game_ctrl.sv
// Directed bench for chimp_game_ctrl built with MAX_LEVEL=5, START_LEVEL=4, LIVES=3.
module tb_chimp_game_ctrl;

  localparam int LVL_W = 3;
  localparam int S_IDLE = 0, S_LOAD = 1, S_WAIT = 2, S_CHOOSE = 3;
  localparam int S_PASS = 4, S_STRIKE = 5, S_OVER = 6;

  logic             clk = 1'b0;
  logic             iResetn, iKey0, iEnter, iLoadAck;
  logic [5:0]       iPressNum;
  logic             oLoadReq, oShowNums, oLevelPass, oStrike, oGameOver, oWin;
  logic [LVL_W-1:0] oLoadIdx, oLevel, oExpect, oScore;
  logic [2:0]       oLives, oState;

  int n_checks = 0;
  int n_errors = 0;

  chimp_game_ctrl #(
    .MAX_LEVEL(5), .START_LEVEL(4), .LIVES(3), .NUM_W(6)
  ) dut (
    .clk(clk), .iResetn(iResetn), .iKey0(iKey0), .iEnter(iEnter),
    .iPressNum(iPressNum), .iLoadAck(iLoadAck),
    .oLoadReq(oLoadReq), .oLoadIdx(oLoadIdx), .oShowNums(oShowNums),
    .oLevel(oLevel), .oExpect(oExpect), .oLives(oLives), .oScore(oScore),
    .oLevelPass(oLevelPass), .oStrike(oStrike), .oGameOver(oGameOver),
    .oWin(oWin), .oState(oState)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic enter();
    iEnter = 1'b1;
    cyc();
    iEnter = 1'b0;
  endtask

  task automatic press(input int n);
    iPressNum = 6'(n);
    cyc();
    iPressNum = 6'd0;
  endtask

  task automatic do_load(input int lvl);
    for (int i = 1; i <= lvl; i++) begin
      chk("load_req", {31'd0, oLoadReq}, 32'd1);
      chk("load_idx", {29'd0, oLoadIdx}, 32'(i));
      iLoadAck = 1'b1;
      cyc();
      iLoadAck = 1'b0;
    end
    chk("load_done_state", {29'd0, oState}, 32'(S_WAIT));
    chk("load_done_req", {31'd0, oLoadReq}, 32'd0);
  endtask

  initial begin
    iResetn = 1'b0; iKey0 = 1'b0; iEnter = 1'b0; iLoadAck = 1'b0; iPressNum = 6'd0;
    cyc(); cyc();
    chk("rst_state", {29'd0, oState}, 32'(S_IDLE));
    chk("rst_level", {29'd0, oLevel}, 32'd4);
    chk("rst_lives", {29'd0, oLives}, 32'd3);
    chk("rst_score", {29'd0, oScore}, 32'd0);
    chk("rst_expect", {29'd0, oExpect}, 32'd1);
    chk("rst_req", {31'd0, oLoadReq}, 32'd0);
    chk("rst_show", {31'd0, oShowNums}, 32'd0);
    iResetn = 1'b1;
    cyc();

    // Plan 1: new game loads tiles 1..4
    enter();
    chk("t1_state", {29'd0, oState}, 32'(S_LOAD));
    iPressNum = 6'd9;
    cyc();
    iPressNum = 6'd0;
    chk("t1_press_ignored", {29'd0, oState}, 32'(S_LOAD));
    do_load(4);
    chk("t1_show", {31'd0, oShowNums}, 32'd1);
    chk("t1_level", {29'd0, oLevel}, 32'd4);

    // Plan 2: clear level 4
    enter();
    chk("t2_choose", {29'd0, oState}, 32'(S_CHOOSE));
    chk("t2_show1", {31'd0, oShowNums}, 32'd1);
    iPressNum = 6'd0; iEnter = 1'b1;
    cyc();
    iEnter = 1'b0;
    chk("t2_hold_state", {29'd0, oState}, 32'(S_CHOOSE));
    chk("t2_hold_expect", {29'd0, oExpect}, 32'd1);
    press(1);
    chk("t2_expect2", {29'd0, oExpect}, 32'd2);
    chk("t2_show_off", {31'd0, oShowNums}, 32'd0);
    press(2);
    press(3);
    chk("t2_expect4", {29'd0, oExpect}, 32'd4);
    press(4);
    chk("t2_pass_state", {29'd0, oState}, 32'(S_PASS));
    chk("t2_pass_pulse", {31'd0, oLevelPass}, 32'd1);
    chk("t2_pass_level", {29'd0, oLevel}, 32'd4);
    cyc();
    chk("t2_pass_drop", {31'd0, oLevelPass}, 32'd0);
    chk("t2_score", {29'd0, oScore}, 32'd4);
    chk("t2_level5", {29'd0, oLevel}, 32'd5);
    chk("t2_req", {31'd0, oLoadReq}, 32'd1);

    // Plan 3: strike at level 5
    do_load(5);
    enter();
    press(1);
    press(3);
    chk("t3_strike_state", {29'd0, oState}, 32'(S_STRIKE));
    chk("t3_strike_pulse", {31'd0, oStrike}, 32'd1);
    cyc();
    chk("t3_strike_drop", {31'd0, oStrike}, 32'd0);
    chk("t3_lives2", {29'd0, oLives}, 32'd2);
    chk("t3_reload_state", {29'd0, oState}, 32'(S_LOAD));
    chk("t3_reload_level", {29'd0, oLevel}, 32'd5);

    // Plan 4: remaining lives lost, including an out-of-range press
    do_load(5);
    enter();
    press(9);
    chk("t4_big_strike", {29'd0, oState}, 32'(S_STRIKE));
    cyc();
    chk("t4_lives1", {29'd0, oLives}, 32'd1);
    do_load(5);
    enter();
    press(2);
    chk("t4_last_strike", {31'd0, oStrike}, 32'd1);
    cyc();
    chk("t4_over_state", {29'd0, oState}, 32'(S_OVER));
    chk("t4_over_flag", {31'd0, oGameOver}, 32'd1);
    chk("t4_over_win", {31'd0, oWin}, 32'd0);
    chk("t4_lives0", {29'd0, oLives}, 32'd0);
    chk("t4_score", {29'd0, oScore}, 32'd4);
    cyc();
    chk("t4_over_hold", {29'd0, oState}, 32'(S_OVER));
    enter();
    chk("t4_idle", {29'd0, oState}, 32'(S_IDLE));
    chk("t4_idle_over", {31'd0, oGameOver}, 32'd0);

    // Plan 5: pass levels 4 and 5 to win
    enter();
    chk("t5_level", {29'd0, oLevel}, 32'd4);
    chk("t5_lives", {29'd0, oLives}, 32'd3);
    chk("t5_score0", {29'd0, oScore}, 32'd0);
    do_load(4);
    enter();
    for (int i = 1; i <= 4; i++) press(i);
    cyc();
    do_load(5);
    enter();
    for (int i = 1; i <= 5; i++) press(i);
    chk("t5_pass5", {31'd0, oLevelPass}, 32'd1);
    cyc();
    chk("t5_over_state", {29'd0, oState}, 32'(S_OVER));
    chk("t5_win", {31'd0, oWin}, 32'd1);
    chk("t5_score5", {29'd0, oScore}, 32'd5);
    chk("t5_level_sat", {29'd0, oLevel}, 32'd5);
    enter();
    chk("t5_idle", {29'd0, oState}, 32'(S_IDLE));
    chk("t5_win_clr", {31'd0, oWin}, 32'd0);

    // Plan 6: iKey0 during a stalled load, then async reset mid-CHOOSE
    enter();
    iLoadAck = 1'b1;
    cyc(); cyc();
    iLoadAck = 1'b0;
    cyc(); cyc();
    chk("t6_stall_req", {31'd0, oLoadReq}, 32'd1);
    chk("t6_stall_idx", {29'd0, oLoadIdx}, 32'd3);
    iKey0 = 1'b1;
    cyc();
    iKey0 = 1'b0;
    chk("t6_key_state", {29'd0, oState}, 32'(S_IDLE));
    chk("t6_key_req", {31'd0, oLoadReq}, 32'd0);
    chk("t6_key_level", {29'd0, oLevel}, 32'd4);
    chk("t6_key_lives", {29'd0, oLives}, 32'd3);
    chk("t6_key_idx", {29'd0, oLoadIdx}, 32'd1);
    enter();
    do_load(4);
    enter();
    press(1);
    chk("t6_pre_rst", {29'd0, oExpect}, 32'd2);
    iResetn = 1'b0;
    #2;
    chk("t6_rst_state", {29'd0, oState}, 32'(S_IDLE));
    chk("t6_rst_req", {31'd0, oLoadReq}, 32'd0);
    chk("t6_rst_level", {29'd0, oLevel}, 32'd4);
    chk("t6_rst_lives", {29'd0, oLives}, 32'd3);
    chk("t6_rst_expect", {29'd0, oExpect}, 32'd1);
    cyc();
    iResetn = 1'b1;
    cyc();
    chk("t6_after_rst", {29'd0, oState}, 32'(S_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
